// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage sitting directly in front of the CU decoder.
//   Holds the program counter, issues one word read at a time to instruction
//   memory over a req/ack handshake and captures the returned word into the
//   instruction register that drives the decoder input.
//
// Ports
//   clk, reset         : single clock, synchronous active-high reset
//   imem_req/imem_addr : read request and word address (imem_addr == pc)
//   imem_ack/imem_rdata: memory response, honoured only while imem_req=1
//   stall              : downstream not ready, hold the presented instruction
//   branch_en/target   : redirect fetch to a new PC (highest after reset)
//   instr/instr_valid  : instruction register and its live flag
//   instr_pc           : address the presented instruction came from
//   halted             : fetch stopped on a halt opcode (constant 0 unless
//                        the HALT_DETECT_EN macro is defined)
//
// Build option
//   HALT_DETECT_EN : when defined, a consumed word whose opcode field [7:4]
//                    is 4'hF parks the fetch in S_HALT until reset or branch.
// ---------------------------------------------------------------------------

// Purpose: PC + imem req/ack fetch feeding a registered instruction to decode.
// Latency: reset release to first instr_valid = 2 cycles + memory wait states.
// Backpressure: stall holds instr/instr_pc/pc and keeps imem_req low until released.
module instr_fetch #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted
);

`ifdef HALT_DETECT_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
  } state_t;
`endif

  // Increment constant sized to the PC so the add wraps modulo 2^ADDR_W.
  localparam logic [ADDR_W-1:0] PC_INC = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] pc;

  // Memory always sees the current PC; the request strobe qualifies it.
  assign imem_addr = pc;

`ifdef HALT_DETECT_EN
  // Opcode 4'hF in the presented word marks a halt instruction.
  logic halt_op;
  assign halt_op = (instr[7:4] == 4'hF);
`else
  assign halted = 1'b0;
`endif

  // Single registered FSM. Priority of the controls at each edge:
  //   reset > branch_en > imem_ack > stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Any outstanding request is abandoned; memory just sees req fall.
      pc          <= RESET_PC;
      state       <= S_IDLE;
      imem_req    <= 1'b0;
      instr       <= 32'h0000_0000;
      instr_valid <= 1'b0;
      instr_pc    <= RESET_PC;
`ifdef HALT_DETECT_EN
      halted      <= 1'b0;
`endif
    end else if (branch_en) begin
      // Redirect from any state. Going through S_IDLE forces req low for one
      // cycle so the next request at the target is seen as a fresh one, and
      // any data returned on this same edge is dropped with the old request.
      // instr itself is left alone; only its valid flag is flushed.
      pc          <= branch_target;
      state       <= S_IDLE;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
`ifdef HALT_DETECT_EN
      halted      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
        end

        S_REQ: begin
          // Request stays up until memory answers; no timeout. stall has no
          // effect here - the register is empty, so there is nothing to hold.
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + PC_INC;
            imem_req    <= 1'b0;
            state       <= S_VALID;
          end
        end

        S_VALID: begin
          // Decoder takes the instruction on any edge where stall is low.
          // instr keeps its old contents after valid drops.
          if (!stall) begin
            instr_valid <= 1'b0;
`ifdef HALT_DETECT_EN
            if (halt_op) begin
              state    <= S_HALT;
              imem_req <= 1'b0;
              halted   <= 1'b1;
            end else begin
              state    <= S_REQ;
              imem_req <= 1'b1;
            end
`else
            state    <= S_REQ;
            imem_req <= 1'b1;
`endif
          end
        end

`ifdef HALT_DETECT_EN
        S_HALT: begin
          // Parked: pc frozen, no requests. Only reset or branch leave here,
          // both handled ahead of this case statement.
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
`endif

        default: begin
          state       <= S_IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
module tb_instr_fetch;
  localparam int         ADDR_W   = 8;
  localparam logic [7:0] RESET_PC = 8'h00;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_en;
  logic [7:0]  branch_target;
  logic [31:0] instr;
  logic        instr_valid;
  logic [7:0]  instr_pc;
  logic        halted;

  int total = 0;
  int bad   = 0;

  // Memory image and responder configuration.
  logic [31:0] mem_img [256];
  int mem_wait = 0;
  bit mem_rand = 1'b0;
  bit mem_junk = 1'b0;

  instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_en(branch_en), .branch_target(branch_target),
    .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Memory responder: answers a request after cur_wait idle cycles, so a
  // request lasts cur_wait+1 cycles. Optionally raises stray acks while idle.
  initial begin : responder
    bit busy;
    int cnt;
    int cur_wait;
    busy = 1'b0; cnt = 0; cur_wait = 0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (imem_req === 1'b1) begin
        if (!busy) begin
          busy = 1'b1;
          cnt = 0;
          cur_wait = mem_rand ? int'($urandom_range(0, 3)) : mem_wait;
        end
        if (cnt == cur_wait) begin
          imem_ack = 1'b1; imem_rdata = mem_img[imem_addr]; busy = 1'b0;
        end else begin
          imem_ack = 1'b0; imem_rdata = $urandom; cnt++;
        end
      end else begin
        busy = 1'b0;
        if (mem_junk && $urandom_range(0, 3) == 0) begin
          imem_ack = 1'b1; imem_rdata = $urandom;
        end else begin
          imem_ack = 1'b0; imem_rdata = 32'h0;
        end
      end
    end
  end

  // Observation point: 2 time units after the edge, after the responder.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!instr_valid && n < limit);
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; branch_en = 1'b0; mem_wait = 0;
    tick();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", instr_valid); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=0", instr); end
    total++; if (instr_pc !== RESET_PC) begin bad++; $display("FAIL reset_instr_pc got=%h want=%h", instr_pc, RESET_PC); end
    total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL reset_addr got=%h want=%h", imem_addr, RESET_PC); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted); end
    tick();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_hold_req got=%b want=0", imem_req); end
    reset = 1'b0;
  endtask

  task automatic test_zero_wait();
    int n;
    for (int a = 0; a < 16; a++) mem_img[a] = 32'(a);
    mem_wait = 0;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_valid(12, n);
      total++; if (n != 2) begin bad++; $display("FAIL zw_spacing k=%0d got=%0d want=2", k, n); end
      total++; if (instr !== 32'(k)) begin bad++; $display("FAIL zw_instr got=%h want=%h", instr, k); end
      total++; if (instr_pc !== 8'(k)) begin bad++; $display("FAIL zw_instr_pc got=%h want=%h", instr_pc, k); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL zw_req_in_valid got=%b want=0", imem_req); end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] prev;
    mem_img[5] = 32'h0000_5505;
    mem_wait = 3;
    branch_en = 1'b1; branch_target = 8'h05;
    tick();
    branch_en = 1'b0;
    total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL ws_after_branch req=%b valid=%b want 0/0", imem_req, instr_valid); end
    prev = instr;
    for (int c = 1; c <= 4; c++) begin
      tick();
      total++; if (imem_req !== 1'b1 || imem_addr !== 8'h05) begin bad++; $display("FAIL ws_req c=%0d req=%b addr=%h want 1/05", c, imem_req, imem_addr); end
      total++; if (instr_valid !== 1'b0 || instr !== prev) begin bad++; $display("FAIL ws_early_capture c=%0d valid=%b instr=%h want 0/%h", c, instr_valid, instr, prev); end
    end
    tick();
    total++; if (instr_valid !== 1'b1 || instr !== 32'h0000_5505 || instr_pc !== 8'h05) begin bad++; $display("FAIL ws_capture valid=%b instr=%h pc=%h want 1/00005505/05", instr_valid, instr, instr_pc); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL ws_req_drop got=%b want=0", imem_req); end
  endtask

  task automatic test_stall();
    int n;
    mem_wait = 0;
    mem_img[6] = 32'hA5A5_0010;
    mem_img[7] = 32'h0000_0707;
    wait_valid(8, n);
    total++; if (instr !== 32'hA5A5_0010 || instr_pc !== 8'h06) begin bad++; $display("FAIL st_load instr=%h pc=%h want a5a50010/06", instr, instr_pc); end
    stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++; if (instr_valid !== 1'b1 || instr !== 32'hA5A5_0010 || instr_pc !== 8'h06 || imem_req !== 1'b0) begin
        bad++; $display("FAIL st_hold c=%0d valid=%b instr=%h pc=%h req=%b", c, instr_valid, instr, instr_pc, imem_req);
      end
    end
    stall = 1'b0;
    tick();
    total++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 8'h07) begin bad++; $display("FAIL st_release req=%b valid=%b addr=%h want 1/0/07", imem_req, instr_valid, imem_addr); end
    tick();
    total++; if (instr_valid !== 1'b1 || instr_pc !== 8'h07 || instr !== 32'h0000_0707) begin bad++; $display("FAIL st_next valid=%b pc=%h instr=%h", instr_valid, instr_pc, instr); end
  endtask

  task automatic test_branch_ack();
    int n;
    logic [31:0] prev;
    mem_wait = 2;
    mem_img[8]    = 32'hDEAD_BEEF;
    mem_img[8'h40] = 32'h1234_0040;
    prev = instr;
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h08) begin bad++; $display("FAIL ba_req req=%b addr=%h want 1/08", imem_req, imem_addr); end
    n = 0;
    while (imem_ack !== 1'b1 && n < 8) begin tick(); n++; end
    total++; if (imem_ack !== 1'b1) begin bad++; $display("FAIL ba_ack_timeout ack=%b want=1", imem_ack); end
    branch_en = 1'b1; branch_target = 8'h40;
    tick();
    branch_en = 1'b0;
    total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL ba_flush req=%b valid=%b want 0/0", imem_req, instr_valid); end
    total++; if (instr !== prev) begin bad++; $display("FAIL ba_discard instr=%h want=%h", instr, prev); end
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h40 || instr_valid !== 1'b0) begin bad++; $display("FAIL ba_refetch req=%b addr=%h valid=%b want 1/40/0", imem_req, imem_addr, instr_valid); end
    wait_valid(10, n);
    total++; if (n != 3) begin bad++; $display("FAIL ba_valid_delay got=%0d want=3", n); end
    total++; if (instr !== 32'h1234_0040 || instr_pc !== 8'h40) begin bad++; $display("FAIL ba_target instr=%h pc=%h want 12340040/40", instr, instr_pc); end
  endtask

  task automatic test_wrap_and_reset();
    int n;
    mem_wait = 0;
    mem_img[8'hFF] = 32'hFF00_0011;
    branch_en = 1'b1; branch_target = 8'hFF;
    tick();
    branch_en = 1'b0;
    wait_valid(8, n);
    total++; if (instr_pc !== 8'hFF || instr !== 32'hFF00_0011) begin bad++; $display("FAIL wr_fetch pc=%h instr=%h want ff/ff000011", instr_pc, instr); end
    mem_wait = 5;
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin bad++; $display("FAIL wr_wrap req=%b addr=%h want 1/00", imem_req, imem_addr); end
    reset = 1'b1;
    tick();
    total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL rm_flags req=%b valid=%b halted=%b want 0/0/0", imem_req, instr_valid, halted); end
    total++; if (instr !== 32'h0 || instr_pc !== RESET_PC || imem_addr !== RESET_PC) begin bad++; $display("FAIL rm_regs instr=%h pc=%h addr=%h want 0/%h/%h", instr, instr_pc, imem_addr, RESET_PC, RESET_PC); end
    reset = 1'b0;
    mem_wait = 0;
  endtask

  task automatic test_halt();
    int n;
    mem_wait = 0;
    mem_img[8'h20] = 32'h0000_00F0;
    mem_img[8'h21] = 32'h0000_0021;
    mem_img[8'h10] = 32'h0000_0010;
    reset = 1'b1; tick(); reset = 1'b0;
    branch_en = 1'b1; branch_target = 8'h20;
    tick();
    branch_en = 1'b0;
    wait_valid(8, n);
    total++; if (instr !== 32'h0000_00F0 || instr_pc !== 8'h20 || halted !== 1'b0) begin bad++; $display("FAIL ht_present instr=%h pc=%h halted=%b", instr, instr_pc, halted); end
    tick();
`ifdef HALT_DETECT_EN
    for (int c = 0; c < 5; c++) begin
      total++; if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL ht_parked c=%0d halted=%b req=%b valid=%b want 1/0/0", c, halted, imem_req, instr_valid); end
      tick();
    end
    branch_en = 1'b1; branch_target = 8'h10;
    tick();
    branch_en = 1'b0;
    total++; if (halted !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL ht_exit halted=%b req=%b want 0/0", halted, imem_req); end
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h10) begin bad++; $display("FAIL ht_refetch req=%b addr=%h want 1/10", imem_req, imem_addr); end
    tick();
    total++; if (instr_valid !== 1'b1 || instr_pc !== 8'h10) begin bad++; $display("FAIL ht_resume valid=%b pc=%h want 1/10", instr_valid, instr_pc); end
`else
    total++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h21) begin bad++; $display("FAIL ht_nohalt halted=%b req=%b addr=%h want 0/1/21", halted, imem_req, imem_addr); end
    tick();
    total++; if (instr_valid !== 1'b1 || instr_pc !== 8'h21 || instr !== 32'h0000_0021) begin bad++; $display("FAIL ht_continue valid=%b pc=%h instr=%h", instr_valid, instr_pc, instr); end
`endif
  endtask

  // Reference model: the decoder must see instructions at consecutive
  // addresses (mod 256) carrying mem_img contents; a branch restarts the
  // sequence at its target and a reset at RESET_PC. Anything presented but
  // not consumed before a branch/reset is simply forgotten.
  task automatic test_random();
    logic [7:0]  exp_addr;
    logic [31:0] w;
    logic [31:0] held;
    logic [7:0]  held_pc;
    bit holding;
    int idle;
    int delivered;
    for (int a = 0; a < 256; a++) begin
      w = $urandom;
      w[7:4] = 4'($urandom_range(0, 14));
      mem_img[a] = w;
    end
    mem_rand = 1'b1; mem_junk = 1'b1;
    reset = 1'b1; stall = 1'b0; branch_en = 1'b0;
    tick();
    reset = 1'b0;
    exp_addr = RESET_PC; holding = 1'b0; held = 32'h0; held_pc = 8'h0;
    idle = 0; delivered = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (instr_valid === 1'b1) begin
        idle = 0;
        if (!holding) begin
          total++; if (instr_pc !== exp_addr || instr !== mem_img[exp_addr]) begin
            bad++; $display("FAIL rnd_deliver cyc=%0d pc=%h instr=%h want %h/%h", cyc, instr_pc, instr, exp_addr, mem_img[exp_addr]);
          end
          holding = 1'b1; held = instr; held_pc = instr_pc; delivered++;
        end else begin
          total++; if (instr !== held || instr_pc !== held_pc) begin
            bad++; $display("FAIL rnd_hold cyc=%0d pc=%h instr=%h want %h/%h", cyc, instr_pc, instr, held_pc, held);
          end
        end
      end else begin
        idle++;
        total++; if (holding) begin bad++; $display("FAIL rnd_lost cyc=%0d valid=%b want=1", cyc, instr_valid); end
        if (idle > 40) begin
          total++; bad++; $display("FAIL rnd_timeout cyc=%0d idle=%0d limit=40", cyc, idle);
          break;
        end
      end
      total++; if (halted !== 1'b0 || (imem_req === 1'b1 && instr_valid === 1'b1)) begin
        bad++; $display("FAIL rnd_flags cyc=%0d halted=%b req=%b valid=%b", cyc, halted, imem_req, instr_valid);
      end
      // Choose inputs for the next edge and advance the model accordingly.
      stall = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 199) == 0);
      branch_en = ($urandom_range(0, 19) == 0);
      branch_target = 8'($urandom_range(0, 255));
      if (reset) begin
        exp_addr = RESET_PC; holding = 1'b0;
      end else if (branch_en) begin
        exp_addr = branch_target; holding = 1'b0;
      end else if (instr_valid === 1'b1 && !stall) begin
        exp_addr = exp_addr + 8'h01; holding = 1'b0;
      end
      tick();
    end
    reset = 1'b0; branch_en = 1'b0; stall = 1'b0;
    mem_rand = 1'b0; mem_junk = 1'b0;
    total++; if (delivered < 200) begin bad++; $display("FAIL rnd_progress delivered=%0d want>=200", delivered); end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_en = 1'b0; branch_target = 8'h00;
    for (int a = 0; a < 256; a++) mem_img[a] = 32'(a);
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_branch_ack();
    test_wrap_and_reset();
    test_halt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
